// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: arbiter state encoding, master indices and default widths.
package cpu_bus_pkg;

  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;

  localparam logic M_FETCH = 1'b0;
  localparam logic M_DATA  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StOwn0,
    StOwn1,
    StAbort0,
    StAbort1
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone classic point-to-point link; master modport drives the request side.
interface wb_arbiter_if
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW,
  parameter int unsigned DW = DEFAULT_DW
);

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            err;
  logic [DW-1:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output ack, err, rdata
  );

endinterface

// File: rtl/wb_watchdog.sv
// Saturating wait counter that pulses expired on the cycle it sits at TIMEOUT while still enabled.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          at_limit;

  assign at_limit = (count_q == CW'(TIMEOUT));

  // A clear in the same cycle (slave terminated) always beats expiry.
  assign expired = enable && !clear && at_limit;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_limit) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with an ack watchdog that aborts stuck cycles.
module wb_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW      = DEFAULT_AW,
  parameter int unsigned DW      = DEFAULT_DW,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master s,
  output logic [1:0]  o_grant
);

  arb_state_e state_q;
  logic       last_grant_q;
  logic [1:0] grant_q;

  logic own;
  logic owner_cyc;
  logic wd_clear;
  logic wd_enable;
  logic timeout_hit;

  assign own       = (state_q == StOwn0) || (state_q == StOwn1);
  assign owner_cyc = (state_q == StOwn0) ? m0.cyc :
                     (state_q == StOwn1) ? m1.cyc : 1'b0;

  // Clearing throughout IDLE covers both the grant edge and an early CYC drop.
  assign wd_clear  = (state_q == StIdle) || s.ack || s.err;
  assign wd_enable = own && owner_cyc;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (timeout_hit)
  );

  assign o_grant = grant_q;

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.addr   = {AW{1'b0}};
    s.wdata  = {DW{1'b0}};
    s.sel    = {(DW/8){1'b0}};
    m0.ack   = 1'b0;
    m0.err   = 1'b0;
    m0.rdata = {DW{1'b0}};
    m1.ack   = 1'b0;
    m1.err   = 1'b0;
    m1.rdata = {DW{1'b0}};
    case (state_q)
      StOwn0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        s.sel    = m0.sel;
        m0.ack   = s.ack;
        m0.err   = s.err || timeout_hit;
        m0.rdata = s.rdata;
      end
      StOwn1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        s.sel    = m1.sel;
        m1.ack   = s.ack;
        m1.err   = s.err || timeout_hit;
        m1.rdata = s.rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= M_DATA;
      grant_q      <= 2'b00;
    end else begin
      case (state_q)
        StIdle: begin
          if (m0.cyc && (!m1.cyc || (last_grant_q == M_DATA))) begin
            state_q      <= StOwn0;
            last_grant_q <= M_FETCH;
            grant_q      <= 2'b01;
          end else if (m1.cyc) begin
            state_q      <= StOwn1;
            last_grant_q <= M_DATA;
            grant_q      <= 2'b10;
          end
        end
        StOwn0: begin
          if (!m0.cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end else if (timeout_hit) begin
            state_q <= StAbort0;
          end
        end
        StOwn1: begin
          if (!m1.cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end else if (timeout_hit) begin
            state_q <= StAbort1;
          end
        end
        StAbort0: begin
          if (!m0.cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
        StAbort1: begin
          if (!m1.cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration, routing, watchdog abort and async reset.
module tb_wb_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] grant;
  int         n_cmp;
  int         n_bad;

  wb_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  wb_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  wb_arbiter_if #(.AW(32), .DW(32)) s_if ();

  wb_arbiter #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (4),
    .CW      (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
    .s       (s_if.master),
    .o_grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.sel = '0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.sel = '0;
    s_if.ack = 0; s_if.err = 0; s_if.rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    n_cmp++;
    if ({s_if.cyc, s_if.stb, grant} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got cyc/stb/grant=%b required 0000", {s_if.cyc, s_if.stb, grant});
      n_bad++;
    end
    step();
    step();
    reset = 1'b0;
    mid();
    n_cmp++;
    if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, s_if.addr} !== 36'h0) begin
      $display("FAIL reset_outs: got %h required 0", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err,
                                                     s_if.addr});
      n_bad++;
    end
  endtask

  task automatic test_single_read();
    step();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h0000_0100; m0_if.sel = 4'hF;
    mid();
    n_cmp++;
    if ({s_if.cyc, grant} !== 3'b000) begin
      $display("FAIL read_latency: got cyc/grant=%b required 000", {s_if.cyc, grant});
      n_bad++;
    end
    step();
    mid();
    n_cmp++;
    if ({s_if.cyc, s_if.stb, grant, s_if.addr} !== {4'b1101, 32'h100}) begin
      $display("FAIL read_grant: got %b/%h required 1101/100", {s_if.cyc, s_if.stb, grant},
               s_if.addr);
      n_bad++;
    end
    step();
    step();
    s_if.ack = 1; s_if.rdata = 32'hDEAD_BEEF;
    mid();
    n_cmp++;
    if ({m0_if.ack, m0_if.err, m1_if.ack, m0_if.rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
      $display("FAIL read_ack: got ack/err/m1ack=%b data=%h required 100 deadbeef",
               {m0_if.ack, m0_if.err, m1_if.ack}, m0_if.rdata);
      n_bad++;
    end
    step();
    idle_inputs();
    step();
    mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      $display("FAIL read_release: got grant=%b required 00", grant);
      n_bad++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h10;
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.addr = 32'h20;
    step();
    s_if.ack = 1;
    mid();
    n_cmp++;
    if ({grant, s_if.addr, m0_if.ack, m1_if.ack} !== {2'b01, 32'h10, 2'b10}) begin
      $display("FAIL tie_first: got grant=%b addr=%h acks=%b required 01 10 10", grant, s_if.addr,
               {m0_if.ack, m1_if.ack});
      n_bad++;
    end
    step();
    s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    step();
    mid();
    n_cmp++;
    if ({grant, s_if.cyc} !== 3'b000) begin
      $display("FAIL tie_idle_gap: got grant/cyc=%b required 000", {grant, s_if.cyc});
      n_bad++;
    end
    step();
    mid();
    n_cmp++;
    if ({grant, s_if.addr} !== {2'b10, 32'h20}) begin
      $display("FAIL tie_second: got grant=%b addr=%h required 10 20", grant, s_if.addr);
      n_bad++;
    end
    step();
    m1_if.cyc = 0; m1_if.stb = 0;
    step();
    m0_if.cyc = 1; m1_if.cyc = 1;
    step();
    mid();
    n_cmp++;
    if (grant !== 2'b01) begin
      $display("FAIL tie_alternate: got grant=%b required 01", grant);
      n_bad++;
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_write_contention();
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 1; m1_if.addr = 32'h2000;
    m1_if.wdata = 32'h1234_5678; m1_if.sel = 4'b0011;
    step();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h44;
    mid();
    n_cmp++;
    if ({grant, s_if.we, s_if.sel, s_if.addr, s_if.wdata} !==
        {2'b10, 1'b1, 4'b0011, 32'h2000, 32'h1234_5678}) begin
      $display("FAIL write_bus: got grant=%b we=%b sel=%b addr=%h data=%h", grant, s_if.we,
               s_if.sel, s_if.addr, s_if.wdata);
      n_bad++;
    end
    step();
    s_if.ack = 1;
    mid();
    n_cmp++;
    if ({m1_if.ack, m0_if.ack} !== 2'b10) begin
      $display("FAIL write_ack_route: got m1/m0 ack=%b required 10", {m1_if.ack, m0_if.ack});
      n_bad++;
    end
    step();
    s_if.ack = 0; m1_if.stb = 0;
    step();
    m1_if.cyc = 0; m1_if.we = 0;
    mid();
    n_cmp++;
    if (grant !== 2'b10) begin
      $display("FAIL write_hold: got grant=%b required 10", grant);
      n_bad++;
    end
    step();
    mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      $display("FAIL write_gap: got grant=%b required 00", grant);
      n_bad++;
    end
    step();
    mid();
    n_cmp++;
    if ({grant, s_if.addr} !== {2'b01, 32'h44}) begin
      $display("FAIL write_m0_next: got grant=%b addr=%h required 01 44", grant, s_if.addr);
      n_bad++;
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    logic [3:0] errs;
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      step();
      mid();
      errs[i] = m0_if.err;
    end
    n_cmp++;
    if (errs !== 4'b0000) begin
      $display("FAIL timeout_early_err: got %b required 0000", errs);
      n_bad++;
    end
    step();
    mid();
    n_cmp++;
    if ({m0_if.err, m0_if.ack, s_if.cyc} !== 3'b101) begin
      $display("FAIL timeout_err: got err/ack/cyc=%b required 101", {m0_if.err, m0_if.ack,
                                                                   s_if.cyc});
      n_bad++;
    end
    step();
    s_if.ack = 1;
    mid();
    n_cmp++;
    if ({m0_if.err, m0_if.ack, s_if.cyc, s_if.stb, grant} !== 6'b000001) begin
      $display("FAIL timeout_abort: got err/ack/cyc/stb/grant=%b required 000001",
               {m0_if.err, m0_if.ack, s_if.cyc, s_if.stb, grant});
      n_bad++;
    end
    step();
    idle_inputs();
    step();
    mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      $display("FAIL timeout_idle: got grant=%b required 00", grant);
      n_bad++;
    end
  endtask

  task automatic test_ack_at_timeout();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h400;
    for (int i = 0; i < 4; i++) step();
    step();
    s_if.ack = 1; s_if.rdata = 32'h0000_CAFE;
    mid();
    n_cmp++;
    if ({m0_if.ack, m0_if.err, m0_if.rdata} !== {2'b10, 32'h0000_CAFE}) begin
      $display("FAIL edge_ack: got ack/err=%b data=%h required 10 cafe", {m0_if.ack, m0_if.err},
               m0_if.rdata);
      n_bad++;
    end
    step();
    s_if.ack = 0;
    mid();
    n_cmp++;
    if ({s_if.cyc, m0_if.err, grant} !== 4'b1001) begin
      $display("FAIL edge_no_abort: got cyc/err/grant=%b required 1001", {s_if.cyc, m0_if.err,
                                                                        grant});
      n_bad++;
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_async_reset();
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.addr = 32'h500;
    step();
    mid();
    n_cmp++;
    if ({s_if.cyc, grant} !== 3'b110) begin
      $display("FAIL areset_pre: got cyc/grant=%b required 110", {s_if.cyc, grant});
      n_bad++;
    end
    step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({s_if.cyc, s_if.stb, grant} !== 4'b0000) begin
      $display("FAIL areset_drop: got cyc/stb/grant=%b required 0000", {s_if.cyc, s_if.stb,
                                                                      grant});
      n_bad++;
    end
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h600;
    step();
    reset = 1'b0;
    step();
    mid();
    n_cmp++;
    if ({grant, s_if.addr} !== {2'b01, 32'h600}) begin
      $display("FAIL areset_tie: got grant=%b addr=%h required 01 600", grant, s_if.addr);
      n_bad++;
    end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_contention();
    test_timeout();
    test_ack_at_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
